// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   F3_*    : RV32I load/store funct3 width/sign codes
//   ST_*    : responder FSM state encodings
//   dmem_req_t : request fields captured when an access is accepted
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store bus between the pipeline (master) and the data memory
// responder (slave).
//   req_valid/req_we/req_funct3/req_addr/req_wdata : request, held stable while stall_m=1
//   stall_m                                        : freeze F/D/X/M
//   resp_valid/resp_rdata/resp_err                 : one-cycle completion pulse and result
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_m;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  stall_m, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output stall_m, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH_WORDS x 32-bit synchronous memory.
//   clock   : rising-edge clock
//   rd_en   : capture mem[rd_idx] into rd_data on the next edge
//   rd_idx  : read word index
//   rd_data : registered read data
//   wr_en   : write enable, qualified per byte by wr_be
//   wr_idx  : write word index
//   wr_be   : byte enables, bit n writes wr_data[8n+7:8n]
//   wr_data : write data
module dmem_array #(
  parameter int    DEPTH_WORDS = 16384,
  parameter string INIT_FILE   = "",
  localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the M-stage load/store bus.
//   clock : rising-edge clock
//   reset : synchronous, active-high; abandons any in-flight access
//   bus   : dmem_responder_if.slave (request in, stall/response out)
// Each access stalls the pipeline for LATENCY cycles (the acceptance cycle
// counts as the first), then completes with a one-cycle resp_valid pulse in
// which stall_m is low. Loads are byte-steered and sign/zero extended; stores
// are written with byte enables during the response cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  function automatic logic req_error(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] off;
    logic        oor, mis, ill;
    off = a - BASE_ADDR;
    oor = (a < BASE_ADDR) || ({1'b0, off} >= SPAN);
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return oor || mis || ill;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'd0, sh[7:0]};
      F3_HU:   return {16'd0, sh[15:0]};
      default: return sh;  // LW is always lane 0, so sh == word
    endcase
  endfunction

  logic [1:0]  state_q;
  logic [3:0]  cnt_q;
  dmem_req_t   req_q;
  logic        err_q;

  logic        accept, to_resp;
  logic        cur_we, cur_err;
  logic [31:0] cur_addr;
  logic [31:0] rd_data;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  // With LATENCY=1 the array is read on the acceptance edge itself, so the
  // read port takes the live request; otherwise it uses the captured one.
  always_comb begin
    cur_we   = req_q.we;
    cur_addr = req_q.addr;
    cur_err  = err_q;
    if (accept) begin
      cur_we   = bus.req_we;
      cur_addr = bus.req_addr;
      cur_err  = req_error(bus.req_funct3, bus.req_addr);
    end
  end

  assign to_resp = (accept && (LATENCY == 1)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  // Control stage: FSM and latency counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request capture stage: inputs are sampled only at acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      req_q <= '{we: bus.req_we, funct3: bus.req_funct3, addr: bus.req_addr, wdata: bus.req_wdata};
      err_q <= req_error(bus.req_funct3, bus.req_addr);
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clock   (clock),
    .rd_en   (to_resp && !cur_we && !cur_err),
    .rd_idx  (IDX_W'((cur_addr - BASE_ADDR) >> 2)),
    .rd_data (rd_data),
    .wr_en   ((state_q == ST_RESP) && req_q.we && !err_q && !reset),
    .wr_idx  (IDX_W'((req_q.addr - BASE_ADDR) >> 2)),
    .wr_be   (store_be(req_q.funct3, req_q.addr[1:0])),
    .wr_data (store_data(req_q.funct3, req_q.wdata))
  );

  assign bus.stall_m    = accept || (state_q == ST_WAIT);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata = ((state_q == ST_RESP) && !req_q.we && !err_q)
                        ? load_extend(req_q.funct3, req_q.addr[1:0], rd_data) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          DEPTH = 16384;
  localparam longint      TOP   = longint'(BASE) + 4 * DEPTH;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2), .INIT_FILE(""))
    u_l2 (.clock(clock), .reset(reset), .bus(bus2));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .INIT_FILE(""))
    u_l1 (.clock(clock), .reset(reset), .bus(bus1));

  // Byte-addressed reference memory; key = {dut select, byte address}
  logic [7:0] mb [bit [32:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit d, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int     size;
    bit     sgn;
    longint a;
    a = longint'(addr);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    er = (size == 0) || (a < longint'(BASE)) || (a >= TOP) || ((size != 0) && (a % size != 0));
    rd = 32'd0;
    if (er) return;
    for (int k = 0; k < size; k++) begin
      if (we) mb[{d, addr + 32'(k)}] = wdata[8*k +: 8];
      else    rd = rd | (32'(mb[{d, addr + 32'(k)}]) << (8 * k));
    end
    if (!we && sgn && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8 * size)) - 32'd1);
  endfunction

  // Drives one request starting just after a rising edge; returns just after
  // the rising edge that ends the response cycle.
  task automatic access(input bit d, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int stalls, output bit got, output int rcyc);
    if (d) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_funct3 = f3;
      bus1.req_addr = addr; bus1.req_wdata = wdata;
    end else begin
      bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_funct3 = f3;
      bus2.req_addr = addr; bus2.req_wdata = wdata;
    end
    stalls = 0; got = 1'b0; rdata = 32'hx; err = 1'bx; rcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (d ? bus1.stall_m : bus2.stall_m) stalls++;
      if (d ? bus1.resp_valid : bus2.resp_valid) begin
        got   = 1'b1;
        rdata = d ? bus1.resp_rdata : bus2.resp_rdata;
        err   = d ? bus1.resp_err : bus2.resp_err;
        rcyc  = cyc;
        break;
      end
      @(posedge clock);
    end
    @(posedge clock);
    #1;
    bus1.req_valid = 1'b0;
    bus2.req_valid = 1'b0;
  endtask

  task automatic run(input string tag, input bit d, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          st, rc;
    bit          got;
    model(d, we, f3, addr, wdata, exp_rd, exp_er);
    access(d, we, f3, addr, wdata, rd, er, st, got, rc);
    check({tag, ".resp_seen"}, 32'(got), 32'd1);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_er));
    check({tag, ".stall_cycles"}, 32'(st), d ? 32'd1 : 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr, wd, exp_rd;
    logic        er, exp_er;
    logic [2:0]  f3;
    int          st, rc, first_rc;
    bit          got, we;

    reset = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd0;
    bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = 3'd0;
    bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("reset.resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("reset.stall_m", 32'(bus2.stall_m), 32'd0);
    check("reset.resp_rdata", bus2.resp_rdata, 32'd0);
    check("reset.resp_err", 32'(bus2.resp_err), 32'd0);
    check("reset.l1_resp_valid", 32'(bus1.resp_valid), 32'd0);
    @(posedge clock);
    #1;

    // Directed scenarios on the LATENCY=2 responder
    run("sw_deadbeef", 0, 1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF);
    run("lw_word4", 0, 0, 3'b010, 32'h0100_0010, 32'h0);
    run("lb_lane3", 0, 0, 3'b000, 32'h0100_0013, 32'h0);
    run("lbu_lane3", 0, 0, 3'b100, 32'h0100_0013, 32'h0);
    run("sh_hi", 0, 1, 3'b001, 32'h0100_0012, 32'h0000_1234);
    run("lw_after_sh", 0, 0, 3'b010, 32'h0100_0010, 32'h0);
    run("lh_hi", 0, 0, 3'b001, 32'h0100_0012, 32'h0);
    run("lw_misaligned", 0, 0, 3'b010, 32'h0100_0011, 32'h0);
    run("sw_below_base", 0, 1, 3'b010, 32'h0000_0000, 32'h5555_5555);
    run("sh_misaligned", 0, 1, 3'b001, 32'h0100_0011, 32'hFFFF_FFFF);
    run("lw_unchanged", 0, 0, 3'b010, 32'h0100_0010, 32'h0);
    run("sw_top_word", 0, 1, 3'b010, 32'h0100_FFFC, 32'h8765_4321);
    run("lhu_top_word", 0, 0, 3'b101, 32'h0100_FFFE, 32'h0);
    run("lw_past_top", 0, 0, 3'b010, 32'h0101_0000, 32'h0);
    run("illegal_f3_011", 0, 0, 3'b011, 32'h0100_0010, 32'h0);
    run("illegal_f3_110", 0, 1, 3'b110, 32'h0100_0010, 32'h0);

    // Reset during the WAIT cycle of a store abandons it
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'h0100_0010; bus2.req_wdata = 32'hCAFE_F00D;
    @(negedge clock);
    check("rst_mid.accept_stall", 32'(bus2.stall_m), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1; bus2.req_valid = 1'b0;
    @(negedge clock);
    check("rst_mid.wait_stall", 32'(bus2.stall_m), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("rst_mid.resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("rst_mid.stall_m", 32'(bus2.stall_m), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mid.no_late_resp", 32'(bus2.resp_valid), 32'd0);
    @(posedge clock);
    #1;
    run("rst_mid.word_kept", 0, 0, 3'b010, 32'h0100_0010, 32'h0);

    // LATENCY=1: four stores, then four back-to-back loads
    for (int i = 0; i < 4; i++)
      run($sformatf("l1_sw%0d", i), 1, 1, 3'b010, BASE + 32'(4 * i), 32'h1111_0000 * 32'(i + 1) + 32'(i));
    first_rc = 0;
    for (int i = 0; i < 4; i++) begin
      model(1, 0, 3'b010, BASE + 32'(4 * i), 32'h0, exp_rd, exp_er);
      access(1, 0, 3'b010, BASE + 32'(4 * i), 32'h0, rd, er, st, got, rc);
      check($sformatf("l1_b2b%0d.rdata", i), rd, exp_rd);
      check($sformatf("l1_b2b%0d.stall_cycles", i), 32'(st), 32'd1);
      if (i == 0) first_rc = rc;
    end
    check("l1_b2b.pulse_span", 32'(rc - first_rc), 32'd6);

    // Randomized traffic against the byte-level reference model
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++)
        run($sformatf("init%0d_w%0d", d, w), d[0], 1, 3'b010, BASE + 32'(4 * w), $urandom);
      if (d == 1) run("init1_top", 1, 1, 3'b010, 32'h0100_FFFC, $urandom);
      for (int n = 0; n < 60; n++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        case ($urandom_range(0, 9))
          0:       addr = BASE - 32'($urandom_range(1, 8));
          1:       addr = BASE + 32'h0001_0000 + 32'($urandom_range(0, 7));
          2:       addr = BASE + 32'h0000_FFFC + 32'($urandom_range(0, 3));
          default: addr = BASE + 32'($urandom_range(0, 63));
        endcase
        run($sformatf("rnd%0d_%0d", d, n), d[0], we, f3, addr, wd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
